// File: rtl/g15_pkg.sv
// Shared G-15 accessory types: adapter state encoding and the FIFO entry
// layout used by the PL19/PL20 host adapters.
package g15_pkg;

  localparam int PL19_DIGIT_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SHIFT
  } pl19_state_t;

  typedef struct packed {
    logic                       stop;
    logic [PL19_DIGIT_BITS-1:0] digit;
  } pl19_entry_t;

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO with occupancy count and registered-memory head;
// a push and a pop may happen in the same cycle, even when full.
module io_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pl19_input_adapter.sv
// PL19 host input adapter: buffers host digits/stop markers and shifts each
// digit MSB-first onto PL19_INPUT under the control switch's bit strobe.
module pl19_input_adapter
  import g15_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   CLOCK,
  input  logic                   rst,
  input  logic [3:0]             in_digit,
  input  logic                   in_stop,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   PL19_START_INPUT,
  input  logic                   PL19_STOP_INPUT,
  input  logic                   PL19_SHIFT_CMD_M20,
  output logic                   PL19_INPUT,
  output logic                   stop_seen,
  output logic                   underrun,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  pl19_state_t                state;
  pl19_state_t                next_state;
  logic [PL19_DIGIT_BITS-1:0] shreg;
  logic [PL19_DIGIT_BITS-1:0] next_shreg;
  logic [1:0]                 bitcnt;
  logic [1:0]                 next_bitcnt;
  logic                       next_underrun;
  logic                       next_stop_seen;
  logic                       pop;
  logic                       fifo_empty;
  pl19_entry_t                head_entry;
  pl19_entry_t                push_entry;

  assign push_entry.stop  = in_stop;
  assign push_entry.digit = in_digit;
  assign fifo_empty       = (fifo_count == '0);
  assign in_ready         = (fifo_count < CW'(DEPTH)) || pop;

  io_fifo #(
    .WIDTH ($bits(pl19_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLOCK),
    .rst       (rst),
    .push      (in_valid && in_ready),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (fifo_count)
  );

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      underrun  <= 1'b0;
      stop_seen <= 1'b0;
    end else begin
      state     <= next_state;
      shreg     <= next_shreg;
      bitcnt    <= next_bitcnt;
      underrun  <= next_underrun;
      stop_seen <= next_stop_seen;
    end
  end

  // Abort beats start and strobe; the fourth strobe of a digit reloads from
  // the FIFO head in the same cycle so no strobe is ever lost between digits.
  always_comb begin
    next_state     = state;
    next_shreg     = shreg;
    next_bitcnt    = bitcnt;
    next_underrun  = underrun;
    next_stop_seen = 1'b0;
    pop            = 1'b0;
    if (PL19_STOP_INPUT) begin
      next_state  = IDLE;
      next_shreg  = '0;
      next_bitcnt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (PL19_START_INPUT) begin
            next_state    = ARMED;
            next_underrun = 1'b0;
          end
        end
        ARMED: begin
          if (!fifo_empty) begin
            pop = 1'b1;
            if (head_entry.stop) begin
              next_stop_seen = 1'b1;
              next_state     = IDLE;
            end else begin
              next_shreg  = head_entry.digit;
              next_bitcnt = '0;
              next_state  = SHIFT;
            end
          end else if (PL19_SHIFT_CMD_M20) begin
            next_underrun = 1'b1;
          end
        end
        SHIFT: begin
          if (PL19_SHIFT_CMD_M20) begin
            if (bitcnt != 2'd3) begin
              next_shreg  = {shreg[PL19_DIGIT_BITS-2:0], 1'b0};
              next_bitcnt = bitcnt + 2'd1;
            end else if (fifo_empty) begin
              next_shreg  = {shreg[PL19_DIGIT_BITS-2:0], 1'b0};
              next_bitcnt = '0;
              next_state  = ARMED;
            end else begin
              pop         = 1'b1;
              next_bitcnt = '0;
              if (head_entry.stop) begin
                next_stop_seen = 1'b1;
                next_shreg     = '0;
                next_state     = IDLE;
              end else begin
                next_shreg = head_entry.digit;
              end
            end
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  assign PL19_INPUT = (state == SHIFT) && shreg[PL19_DIGIT_BITS-1];
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_pl19_input_adapter.sv
// Self-checking bench for pl19_input_adapter: expected serial bits are queued
// when digits are pushed and popped as each strobe consumes a bit.
module tb_pl19_input_adapter;

  localparam int DEPTH = 8;

  logic       CLOCK;
  logic       rst;
  logic [3:0] in_digit;
  logic       in_stop;
  logic       in_valid;
  logic       in_ready;
  logic       PL19_START_INPUT;
  logic       PL19_STOP_INPUT;
  logic       PL19_SHIFT_CMD_M20;
  logic       PL19_INPUT;
  logic       stop_seen;
  logic       underrun;
  logic       busy;
  logic [3:0] fifo_count;

  int   checks = 0;
  int   fails  = 0;
  logic exp_q[$];
  logic exp_bit;

  pl19_input_adapter #(.DEPTH(DEPTH)) dut (
    .CLOCK              (CLOCK),
    .rst                (rst),
    .in_digit           (in_digit),
    .in_stop            (in_stop),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .PL19_START_INPUT   (PL19_START_INPUT),
    .PL19_STOP_INPUT    (PL19_STOP_INPUT),
    .PL19_SHIFT_CMD_M20 (PL19_SHIFT_CMD_M20),
    .PL19_INPUT         (PL19_INPUT),
    .stop_seen          (stop_seen),
    .underrun           (underrun),
    .busy               (busy),
    .fifo_count         (fifo_count)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_entry(input logic [3:0] d, input logic s);
    in_digit = d;
    in_stop  = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_stop  = 1'b0;
    if (!s) begin
      for (int i = 3; i >= 0; i--) exp_q.push_back(d[i]);
    end
  endtask

  task automatic pulse_start;
    PL19_START_INPUT = 1'b1;
    tick();
    PL19_START_INPUT = 1'b0;
  endtask

  task automatic pulse_strobe;
    PL19_SHIFT_CMD_M20 = 1'b1;
    tick();
    PL19_SHIFT_CMD_M20 = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (fifo_count !== 4'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (PL19_INPUT !== 1'b0) begin fails++; $display("[TB] FAIL reset_out: got %0b want 0", PL19_INPUT); end
    checks++; if (stop_seen !== 1'b0) begin fails++; $display("[TB] FAIL reset_stop_seen: got %0b want 0", stop_seen); end
    checks++; if (underrun !== 1'b0) begin fails++; $display("[TB] FAIL reset_underrun: got %0b want 0", underrun); end
  endtask

  task automatic test_basic_shift;
    do_reset();
    push_entry(4'hA, 1'b0);
    push_entry(4'h5, 1'b0);
    pulse_start();
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_bit = exp_q.pop_front();
      checks++; if (PL19_INPUT !== exp_bit) begin fails++; $display("[TB] FAIL basic_bit%0d: got %0b want %0b", i, PL19_INPUT, exp_bit); end
      pulse_strobe();
    end
    checks++; if (underrun !== 1'b0) begin fails++; $display("[TB] FAIL basic_underrun: got %0b want 0", underrun); end
    checks++; if (busy !== 1'b1 || dut.state !== g15_pkg::ARMED) begin fails++; $display("[TB] FAIL basic_armed: got state %0d busy %0b want ARMED", dut.state, busy); end
    checks++; if (PL19_INPUT !== 1'b0) begin fails++; $display("[TB] FAIL basic_out_armed: got %0b want 0", PL19_INPUT); end
  endtask

  task automatic test_stop_marker;
    do_reset();
    push_entry(4'h3, 1'b0);
    push_entry(4'h0, 1'b1);
    pulse_start();
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_bit = exp_q.pop_front();
      checks++; if (PL19_INPUT !== exp_bit) begin fails++; $display("[TB] FAIL stop_bit%0d: got %0b want %0b", i, PL19_INPUT, exp_bit); end
      checks++; if (stop_seen !== 1'b0) begin fails++; $display("[TB] FAIL stop_early%0d: got %0b want 0", i, stop_seen); end
      pulse_strobe();
    end
    checks++; if (stop_seen !== 1'b1) begin fails++; $display("[TB] FAIL stop_pulse: got %0b want 1", stop_seen); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL stop_busy: got %0b want 0", busy); end
    tick();
    checks++; if (stop_seen !== 1'b0) begin fails++; $display("[TB] FAIL stop_pulse_len: got %0b want 0", stop_seen); end
    checks++; if (fifo_count !== 4'd0) begin fails++; $display("[TB] FAIL stop_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_full_fifo;
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_entry(4'(i + 1), 1'b0);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL full_in_ready: got %0b want 0", in_ready); end
    checks++; if (fifo_count !== 4'(DEPTH)) begin fails++; $display("[TB] FAIL full_count: got %0d want %0d", fifo_count, DEPTH); end
    pulse_start();
    in_digit = 4'hE;
    in_stop  = 1'b0;
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL full_ready_on_pop: got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int i = 3; i >= 0; i--) exp_q.push_back(1'(4'hE >> i));
    checks++; if (fifo_count !== 4'(DEPTH)) begin fails++; $display("[TB] FAIL full_count_after: got %0d want %0d", fifo_count, DEPTH); end
    for (int i = 0; i < 8; i++) begin
      exp_bit = exp_q.pop_front();
      checks++; if (PL19_INPUT !== exp_bit) begin fails++; $display("[TB] FAIL full_bit%0d: got %0b want %0b", i, PL19_INPUT, exp_bit); end
      pulse_strobe();
    end
    checks++; if (fifo_count !== 4'(DEPTH - 2)) begin fails++; $display("[TB] FAIL full_count_drain: got %0d want %0d", fifo_count, DEPTH - 2); end
  endtask

  task automatic test_underrun;
    do_reset();
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      checks++; if (PL19_INPUT !== 1'b0) begin fails++; $display("[TB] FAIL under_out%0d: got %0b want 0", i, PL19_INPUT); end
      pulse_strobe();
    end
    checks++; if (underrun !== 1'b1) begin fails++; $display("[TB] FAIL under_flag: got %0b want 1", underrun); end
    push_entry(4'hF, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_bit = exp_q.pop_front();
      checks++; if (PL19_INPUT !== exp_bit) begin fails++; $display("[TB] FAIL under_bit%0d: got %0b want %0b", i, PL19_INPUT, exp_bit); end
      pulse_strobe();
    end
    checks++; if (underrun !== 1'b1) begin fails++; $display("[TB] FAIL under_sticky: got %0b want 1", underrun); end
    PL19_STOP_INPUT = 1'b1;
    tick();
    PL19_STOP_INPUT = 1'b0;
    pulse_start();
    checks++; if (underrun !== 1'b0) begin fails++; $display("[TB] FAIL under_clear: got %0b want 0", underrun); end
  endtask

  task automatic test_abort;
    do_reset();
    push_entry(4'hC, 1'b0);
    push_entry(4'h9, 1'b0);
    pulse_start();
    tick();
    for (int i = 0; i < 2; i++) begin
      exp_bit = exp_q.pop_front();
      checks++; if (PL19_INPUT !== exp_bit) begin fails++; $display("[TB] FAIL abort_bit%0d: got %0b want %0b", i, PL19_INPUT, exp_bit); end
      pulse_strobe();
    end
    PL19_STOP_INPUT    = 1'b1;
    PL19_SHIFT_CMD_M20 = 1'b1;
    tick();
    PL19_STOP_INPUT    = 1'b0;
    PL19_SHIFT_CMD_M20 = 1'b0;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_idle: got busy %0b want 0", busy); end
    checks++; if (fifo_count !== 4'd1) begin fails++; $display("[TB] FAIL abort_count: got %0d want 1", fifo_count); end
    checks++; if (PL19_INPUT !== 1'b0) begin fails++; $display("[TB] FAIL abort_out: got %0b want 0", PL19_INPUT); end
    pulse_start();
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_bit = exp_q.pop_front();
      checks++; if (PL19_INPUT !== exp_bit) begin fails++; $display("[TB] FAIL abort_restart_bit%0d: got %0b want %0b", i, PL19_INPUT, exp_bit); end
      pulse_strobe();
    end
  endtask

  task automatic test_reset_mid_shift;
    do_reset();
    pulse_start();
    pulse_strobe();
    push_entry(4'h6, 1'b0);
    push_entry(4'h9, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_bit = exp_q.pop_front();
      checks++; if (PL19_INPUT !== exp_bit) begin fails++; $display("[TB] FAIL midrst_bit%0d: got %0b want %0b", i, PL19_INPUT, exp_bit); end
      pulse_strobe();
    end
    checks++; if (underrun !== 1'b1 || fifo_count !== 4'd1) begin fails++; $display("[TB] FAIL midrst_pre: got underrun %0b count %0d want 1 1", underrun, fifo_count); end
    rst                = 1'b1;
    PL19_SHIFT_CMD_M20 = 1'b1;
    PL19_START_INPUT   = 1'b1;
    tick();
    rst                = 1'b0;
    PL19_SHIFT_CMD_M20 = 1'b0;
    PL19_START_INPUT   = 1'b0;
    exp_q.delete();
    checks++; if (PL19_INPUT !== 1'b0) begin fails++; $display("[TB] FAIL midrst_out: got %0b want 0", PL19_INPUT); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %0b want 0", busy); end
    checks++; if (underrun !== 1'b0) begin fails++; $display("[TB] FAIL midrst_underrun: got %0b want 0", underrun); end
    checks++; if (stop_seen !== 1'b0) begin fails++; $display("[TB] FAIL midrst_stop_seen: got %0b want 0", stop_seen); end
    checks++; if (fifo_count !== 4'd0) begin fails++; $display("[TB] FAIL midrst_count: got %0d want 0", fifo_count); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL midrst_in_ready: got %0b want 1", in_ready); end
  endtask

  initial begin
    rst                = 1'b1;
    in_digit           = 4'h0;
    in_stop            = 1'b0;
    in_valid           = 1'b0;
    PL19_START_INPUT   = 1'b0;
    PL19_STOP_INPUT    = 1'b0;
    PL19_SHIFT_CMD_M20 = 1'b0;
    $display("[TB] starting pl19_input_adapter bench");
    test_reset();
    test_basic_shift();
    test_stop_marker();
    test_full_fifo();
    test_underrun();
    test_abort();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pl19_input_adapter.md
# pl19_input_adapter

Host-side input adapter for the G-15 accessory connector PL19. It buffers 4-bit digits and stop markers from the host (tape-reader/typewriter emulation) in a small FIFO. It arms on the control switch's start-input strobe and serialises each digit MSB-first onto `PL19_INPUT` under the control switch's `PL19_SHIFT_CMD_M20` bit strobe. It sits directly upstream of the control switch's accessory interface.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, minimum 2.

Ports:
- `CLOCK`, input, 1: system bit clock. One clock domain only.
- `rst`, input, 1: synchronous, active-high reset.
- `in_digit`, input, 4: host digit, bit 3 is shifted first.
- `in_stop`, input, 1: entry is a stop marker; `in_digit` is ignored.
- `in_valid`, input, 1: host offers an entry.
- `in_ready`, output, 1: FIFO can accept an entry.
- `PL19_START_INPUT`, input, 1: arm request (level, sampled each cycle).
- `PL19_STOP_INPUT`, input, 1: abort request.
- `PL19_SHIFT_CMD_M20`, input, 1: bit strobe; one bit is consumed per high cycle.
- `PL19_INPUT`, output, 1: serial data bit to the control switch.
- `stop_seen`, output, 1: one-cycle pulse when a stop marker is popped.
- `underrun`, output, 1: sticky flag; set when a strobe arrives while no bit is available.
- `busy`, output, 1: state is not IDLE.
- `fifo_count`, output, $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Push.** An entry is pushed when `in_valid & in_ready`. `in_ready = (count < DEPTH) | pop_this_cycle`, so a full FIFO accepts a push in the same cycle as a pop.
- **States:** IDLE, ARMED, SHIFT.
- **IDLE → ARMED** on `PL19_START_INPUT`. Start has no effect while the block is already ARMED or in SHIFT.
- **ARMED, FIFO non-empty:** pop the head.
  - Stop marker: pulse `stop_seen` and go to IDLE.
  - Digit: load the shift register, set `bitcnt` to 0, go to SHIFT.
- **ARMED, FIFO empty:** hold. A strobe in this state sets `underrun`; `PL19_INPUT` is 0.
- **SHIFT, on strobe:** shift the register left by one and increment `bitcnt`.
- **SHIFT, fourth strobe (`bitcnt` = 3):**
  - Head is a digit: pop it and reload in the same cycle, staying in SHIFT with `bitcnt` = 0. There is no lost strobe.
  - Head is a stop marker: pop it, pulse `stop_seen`, go to IDLE.
  - FIFO empty: go to ARMED.
- **Output.** `PL19_INPUT = shreg[3]` when in SHIFT, otherwise 0. It is combinational from the registered `shreg` and `state`.
- **Abort.** `PL19_STOP_INPUT` in any state forces IDLE on the next edge. Any partial digit is discarded. FIFO contents are kept. Stop has priority over start and over strobe in the same cycle.
- **Clearing `underrun`.** Only `rst` clears it, or a `PL19_START_INPUT` seen while in IDLE.

## Timing
- **Reset values:** state IDLE, FIFO empty, `shreg` 0, `bitcnt` 0, `PL19_INPUT` 0, `stop_seen` 0, `underrun` 0, `busy` 0, `in_ready` 1, `fifo_count` 0.
- **Push to visibility:** an entry pushed at edge N is poppable from edge N+1.
- **Start to load:** a start at edge N (FIFO non-empty) produces ARMED at N+1 and SHIFT at N+2. The first bit is valid on `PL19_INPUT` from N+2.
- **Bit advance:** a strobe sampled at edge N advances `PL19_INPUT` for cycle N+1. Back-to-back strobes on every cycle are supported.
- **Reset mid-shift:** wins over every other input. All state returns to reset values, including the FIFO contents.

## Structure
- **Shared package `g15_pkg`** holds:
  - `pl19_state_t`, an enum with values IDLE, ARMED, SHIFT;
  - `pl19_entry_t`, a packed struct `{stop, digit[3:0]}`;
  - `PL19_DIGIT_BITS = 4`.
- **Sub-module `io_fifo`:** a synchronous FIFO parameterised on width and DEPTH. Its outputs are `count` and `head`, and it supports a simultaneous push and pop. It is reusable for the output-side PL20 adapter.

## Test plan
- **Basic shift.**
  - Stimulus: reset, push digits 0xA and 0x5, pulse start, then 8 consecutive strobes.
  - Required response: `PL19_INPUT` sequence 1,0,1,0,0,1,0,1, `underrun` 0, state ARMED at the end.
- **Stop marker.**
  - Stimulus: push 0x3 then a stop marker, start, then 4 strobes.
  - Required response: bits 0,0,1,1, then `stop_seen` pulses for exactly 1 cycle, followed by IDLE and `busy` 0.
- **Full FIFO.**
  - Stimulus: with DEPTH=8 and not started, push 8 entries.
  - Required response: `in_ready` 0 and `fifo_count` 8.
  - Continuation: start the block and hold `in_valid` during the first pop. The push is accepted in that same cycle and `fifo_count` stays at 8.
- **Underrun.**
  - Stimulus: start with the FIFO empty, then 2 strobes.
  - Required response: `PL19_INPUT` 0 and `underrun` 1.
  - Continuation: push 0xF; the next 4 strobes give 1,1,1,1 and `underrun` remains 1.
- **Abort.**
  - Stimulus: push 0xC and 0x9, start, 2 strobes, then assert stop together with a strobe.
  - Required response: IDLE the next cycle and `fifo_count` 1.
  - Continuation: restart the block; 4 strobes give 1,0,0,1.
- **Reset mid-shift.**
  - Stimulus: assert `rst` during the 3rd bit of a digit.
  - Required response: all outputs take their reset values on the next edge and `fifo_count` is 0.
